dds_phase_acc: RTL and testbench

DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

---
 rtl/dds_phase_acc.sv | 162 ++++++++++++++++
 tb/tb_dds_phase_acc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator driving a 4-waveform ROM address {wave, index}.
// Retunes issued while running are held in a shadow set until the next phase wrap.
module dds_phase_acc #(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ACC_W-1:0]    cfg_fword,
    input  logic [LUT_AW-1:0]   cfg_poff,
    input  logic [1:0]          cfg_wave,
    output logic [LUT_AW+1:0]   rom_ad,
    output logic                rom_ce,
    output logic                rom_oce,
    output logic                rom_reset,
    output logic                sample_valid,
    output logic                wrap,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    // Handshake: a config transfers on a rising clk edge where cfg_valid && cfg_ready;
    // cfg_ready is low exactly while a shadow config is waiting to be applied.

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    fword_a_q, fword_a_d, fword_s_q, fword_s_d;
    logic [LUT_AW-1:0]   poff_a_q, poff_a_d, poff_s_q, poff_s_d;
    logic [1:0]          wave_a_q, wave_a_d, wave_s_q, wave_s_d;
    logic                pending_q, pending_d;
    logic [LUT_AW+1:0]   rom_ad_q, rom_ad_d;
    logic                wrap_q, wrap_d;
    logic                issue_q, sample_valid_q;
    logic                rom_reset_q;

    logic [ACC_W:0]      sum;
    logic                carry;
    logic                accept;
    logic [LUT_AW-1:0]   index;

    assign sum    = {1'b0, acc_q} + {1'b0, fword_a_q};
    assign carry  = en & sum[ACC_W];
    assign accept = cfg_valid & ~pending_q;
    assign index  = acc_q[ACC_W-1 -: LUT_AW] + poff_a_q;

    always_comb begin
        acc_d     = acc_q;
        rom_ad_d  = rom_ad_q;
        fword_a_d = fword_a_q;
        poff_a_d  = poff_a_q;
        wave_a_d  = wave_a_q;
        fword_s_d = fword_s_q;
        poff_s_d  = poff_s_q;
        wave_s_d  = wave_s_q;
        pending_d = pending_q;
        wrap_d    = carry;

        if (en) begin
            acc_d    = sum[ACC_W-1:0];
            rom_ad_d = {wave_a_q, index};
        end

        // Shadow commits on a wrap, immediately if fword is 0 (no wrap can come), or when stopping.
        if (pending_q && (!en || carry || (fword_a_q == '0))) begin
            fword_a_d = fword_s_q;
            poff_a_d  = poff_s_q;
            wave_a_d  = wave_s_q;
            pending_d = 1'b0;
        end

        if (accept) begin
            if (en) begin
                fword_s_d = cfg_fword;
                poff_s_d  = cfg_poff;
                wave_s_d  = cfg_wave;
                pending_d = 1'b1;
            end else begin
                fword_a_d = cfg_fword;
                poff_a_d  = cfg_poff;
                wave_a_d  = cfg_wave;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = en ? (pending_d ? S_PEND : S_RUN) : S_IDLE;
            S_RUN:   state_d = en ? (pending_d ? S_PEND : S_RUN) : S_IDLE;
            S_PEND:  state_d = en ? (pending_d ? S_PEND : S_RUN) : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = ~pending_q;
        rom_ce    = (state_q != S_IDLE);
        rom_oce   = 1'b1;
        dbg_state = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q          <= '0;
            fword_a_q      <= '0;
            poff_a_q       <= '0;
            wave_a_q       <= '0;
            fword_s_q      <= '0;
            poff_s_q       <= '0;
            wave_s_q       <= '0;
            pending_q      <= 1'b0;
            rom_ad_q       <= '0;
            wrap_q         <= 1'b0;
            issue_q        <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            fword_a_q      <= fword_a_d;
            poff_a_q       <= poff_a_d;
            wave_a_q       <= wave_a_d;
            fword_s_q      <= fword_s_d;
            poff_s_q       <= poff_s_d;
            wave_s_q       <= wave_s_d;
            pending_q      <= pending_d;
            rom_ad_q       <= rom_ad_d;
            wrap_q         <= wrap_d;
            issue_q        <= en;
            sample_valid_q <= issue_q;
        end
    end

    // Held high through reset and for the first cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_reset_q <= 1'b1;
        end else begin
            rom_reset_q <= 1'b0;
        end
    end

    assign rom_ad       = rom_ad_q;
    assign wrap         = wrap_q;
    assign sample_valid = sample_valid_q;
    assign rom_reset    = rom_reset_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Self-checking bench for dds_phase_acc: loads, retunes, offset wrap, wave switch, reset and stop/resume.
module tb_dds_phase_acc;
    localparam int ACC_W  = 32;
    localparam int LUT_AW = 10;
    localparam int AD_W   = LUT_AW + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              en = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [ACC_W-1:0]  cfg_fword = '0;
    logic [LUT_AW-1:0] cfg_poff = '0;
    logic [1:0]        cfg_wave = '0;
    logic [AD_W-1:0]   rom_ad;
    logic              rom_ce, rom_oce, rom_reset, sample_valid, wrap;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AD_W-1:0] exp_q[$];
    logic [AD_W-1:0] exp_ad;

    dds_phase_acc #(.ACC_W(ACC_W), .LUT_AW(LUT_AW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_fword(cfg_fword), .cfg_poff(cfg_poff), .cfg_wave(cfg_wave), .rom_ad(rom_ad),
        .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
        .sample_valid(sample_valid), .wrap(wrap), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        en = 1'b0; cfg_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic idle_load(input logic [ACC_W-1:0] fw, input logic [LUT_AW-1:0] po, input logic [1:0] wv);
        cfg_fword = fw; cfg_poff = po; cfg_wave = wv;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rom_ad !== '0) begin n_fail++; $display("FAIL rst_rom_ad: got %h expected 0", rom_ad); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL rst_wrap: got %b expected 0", wrap); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_sv: got %b expected 0", sample_valid); end
        n_checks++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL rst_rom_ce: got %b expected 0", rom_ce); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got %b expected 1", cfg_ready); end
        n_checks++; if (rom_oce !== 1'b1) begin n_fail++; $display("FAIL rst_rom_oce: got %b expected 1", rom_oce); end
        n_checks++; if (rom_reset !== 1'b1) begin n_fail++; $display("FAIL rst_rom_reset: got %b expected 1", rom_reset); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (rom_reset !== 1'b1) begin n_fail++; $display("FAIL rel_rom_reset_hi: got %b expected 1", rom_reset); end
        tick();
        n_checks++; if (rom_reset !== 1'b0) begin n_fail++; $display("FAIL rel_rom_reset_lo: got %b expected 0", rom_reset); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rel_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_idle_load;
        do_reset();
        idle_load(32'h4000_0000, 10'd0, 2'd0);
        for (int k = 0; k < 8; k++) exp_q.push_back({2'd0, 10'(256 * (k % 4))});
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL idle_ad k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
            n_checks++; if (wrap !== ((k % 4) == 3)) begin n_fail++; $display("FAIL idle_wrap k=%0d: got %b expected %b", k, wrap, (k % 4) == 3); end
            n_checks++; if (sample_valid !== (k >= 1)) begin n_fail++; $display("FAIL idle_sv k=%0d: got %b expected %b", k, sample_valid, k >= 1); end
            n_checks++; if (rom_ce !== 1'b1) begin n_fail++; $display("FAIL idle_ce k=%0d: got %b expected 1", k, rom_ce); end
        end
        en = 1'b0;
        tick();
        n_checks++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL stop_ce: got %b expected 0", rom_ce); end
        n_checks++; if (rom_ad !== {2'd0, 10'd768}) begin n_fail++; $display("FAIL stop_ad: got %h expected %h", rom_ad, {2'd0, 10'd768}); end
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL stop_sv_tail: got %b expected 1", sample_valid); end
        tick();
        n_checks++; if (rom_ad !== {2'd0, 10'd768}) begin n_fail++; $display("FAIL hold_ad: got %h expected %h", rom_ad, {2'd0, 10'd768}); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL hold_sv: got %b expected 0", sample_valid); end
    endtask

    task automatic test_retune;
        do_reset();
        idle_load(32'h0100_0000, 10'd0, 2'd0);
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back({2'd0, 10'(4 * k)});
            tick();
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL rt_pre_ad k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
        end
        cfg_fword = 32'h0200_0000; cfg_valid = 1'b1;
        exp_q.push_back({2'd0, 10'd40});
        tick();
        cfg_fword = 32'h0800_0000;
        exp_ad = exp_q.pop_front();
        n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL rt_acc_ad: got %h expected %h", rom_ad, exp_ad); end
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rt_ready_lo: got %b expected 0", cfg_ready); end
        n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rt_state_pend: got %0d expected 2", dbg_state); end
        // cfg_valid stays high with a different word while pending; it must be ignored
        for (int k = 0; k < 245; k++) begin
            exp_q.push_back({2'd0, 10'(44 + 4 * k)});
            tick();
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL rt_mid_ad k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
            n_checks++; if (cfg_ready !== (k == 244)) begin n_fail++; $display("FAIL rt_ready k=%0d: got %b expected %b", k, cfg_ready, k == 244); end
            n_checks++; if (wrap !== (k == 244)) begin n_fail++; $display("FAIL rt_wrap k=%0d: got %b expected %b", k, wrap, k == 244); end
        end
        cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({2'd0, 10'(8 * k)});
            tick();
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL rt_post_ad k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
        end
        n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL rt_state_run: got %0d expected 1", dbg_state); end
    endtask

    task automatic test_carry_accept;
        do_reset();
        idle_load(32'h4000_0000, 10'd0, 2'd0);
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back({2'd0, (k < 8) ? 10'(256 * (k % 4)) : 10'(128 * (k - 8))});
            if (k == 3) begin cfg_fword = 32'h2000_0000; cfg_valid = 1'b1; end
            tick();
            cfg_valid = 1'b0;
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL ca_ad k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
            n_checks++; if (cfg_ready !== !(k >= 3 && k <= 6)) begin n_fail++; $display("FAIL ca_ready k=%0d: got %b expected %b", k, cfg_ready, !(k >= 3 && k <= 6)); end
            n_checks++; if (wrap !== (k == 3 || k == 7)) begin n_fail++; $display("FAIL ca_wrap k=%0d: got %b expected %b", k, wrap, k == 3 || k == 7); end
        end
    endtask

    task automatic test_poff;
        do_reset();
        idle_load(32'h0040_0000, 10'd1000, 2'd0);
        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            exp_q.push_back({2'd0, 10'((1000 + k) % 1024)});
            tick();
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL poff_ad k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
        end
    endtask

    task automatic test_wave_switch;
        do_reset();
        idle_load(32'h0, 10'd0, 2'd3);
        en = 1'b1;
        tick();
        n_checks++; if (rom_ad !== {2'd3, 10'd0}) begin n_fail++; $display("FAIL ws_init: got %h expected %h", rom_ad, {2'd3, 10'd0}); end
        cfg_fword = 32'h0; cfg_poff = 10'd0; cfg_wave = 2'd1; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (rom_ad[11:10] !== 2'd3) begin n_fail++; $display("FAIL ws_edge1: got %0d expected 3", rom_ad[11:10]); end
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ws_ready_lo: got %b expected 0", cfg_ready); end
        tick();
        n_checks++; if (rom_ad[11:10] !== 2'd3) begin n_fail++; $display("FAIL ws_edge2: got %0d expected 3", rom_ad[11:10]); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ws_ready_hi: got %b expected 1", cfg_ready); end
        tick();
        n_checks++; if (rom_ad[11:10] !== 2'd1) begin n_fail++; $display("FAIL ws_edge3: got %0d expected 1", rom_ad[11:10]); end
    endtask

    task automatic test_reset_pending;
        do_reset();
        idle_load(32'h0100_0000, 10'd3, 2'd2);
        en = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (rom_ad !== {2'd2, 10'd11}) begin n_fail++; $display("FAIL rp_pre_ad: got %h expected %h", rom_ad, {2'd2, 10'd11}); end
        cfg_fword = 32'h0200_0000; cfg_poff = 10'd5; cfg_wave = 2'd1; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rp_pending: got %b expected 0", cfg_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rom_ad !== '0) begin n_fail++; $display("FAIL rp_ad: got %h expected 0", rom_ad); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rp_sv: got %b expected 0", sample_valid); end
        n_checks++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL rp_ce: got %b expected 0", rom_ce); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rp_ready: got %b expected 1", cfg_ready); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL rp_wrap: got %b expected 0", wrap); end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (rom_reset !== 1'b1) begin n_fail++; $display("FAIL rp_rom_reset_hi: got %b expected 1", rom_reset); end
        tick();
        n_checks++; if (rom_reset !== 1'b0) begin n_fail++; $display("FAIL rp_rom_reset_lo: got %b expected 0", rom_reset); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rp_ready_rel: got %b expected 1", cfg_ready); end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('0);
            tick();
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL rp_discard k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
        end
    endtask

    task automatic test_en_drop;
        do_reset();
        idle_load(32'h0100_0000, 10'd0, 2'd0);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({2'd0, 10'(4 * k)});
            tick();
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL ed_pre_ad k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
        end
        cfg_fword = 32'h0040_0000; cfg_poff = 10'd0; cfg_wave = 2'd2; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (rom_ad !== {2'd0, 10'd12}) begin n_fail++; $display("FAIL ed_acc_ad: got %h expected %h", rom_ad, {2'd0, 10'd12}); end
        n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL ed_state_pend: got %0d expected 2", dbg_state); end
        en = 1'b0;
        tick();
        n_checks++; if (rom_ce !== 1'b0) begin n_fail++; $display("FAIL ed_ce: got %b expected 0", rom_ce); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ed_ready: got %b expected 1", cfg_ready); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL ed_state_idle: got %0d expected 0", dbg_state); end
        tick(); tick();
        n_checks++; if (rom_ad !== {2'd0, 10'd12}) begin n_fail++; $display("FAIL ed_hold_ad: got %h expected %h", rom_ad, {2'd0, 10'd12}); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL ed_hold_sv: got %b expected 0", sample_valid); end
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({2'd2, 10'(16 + k)});
            tick();
            exp_ad = exp_q.pop_front();
            n_checks++; if (rom_ad !== exp_ad) begin n_fail++; $display("FAIL ed_resume_ad k=%0d: got %h expected %h", k, rom_ad, exp_ad); end
            n_checks++; if (sample_valid !== (k >= 1)) begin n_fail++; $display("FAIL ed_resume_sv k=%0d: got %b expected %b", k, sample_valid, k >= 1); end
            n_checks++; if (rom_ce !== 1'b1) begin n_fail++; $display("FAIL ed_resume_ce k=%0d: got %b expected 1", k, rom_ce); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_load();
        test_retune();
        test_carry_accept();
        test_poff();
        test_wave_switch();
        test_reset_pending();
        test_en_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
